tea_job_arbiter: RTL

- Scheduler in front of the shared TEA accelerator core. It arbitrates two requesters (port 0: CPU register path; port 1: DMA/streaming path) round-robin.
- For each job it issues one encrypt/decrypt operation to the core, waits for completion with a timeout, and returns the 64-bit result over a valid/ready response channel.
- It sits between the requesters and the core's v0/v1 data and start/done signals. Keys are supplied to the core directly and are not routed through this block.

---
 rtl/tea_job_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tea_job_arbiter.sv
// tea_job_arbiter: round-robin job scheduler in front of the shared TEA core.
// Two requesters (port 0 CPU, port 1 DMA) submit 64-bit {v1, v0} jobs. One job
// is in flight at a time. Each job is issued to the core, awaited with a
// timeout, and returned on the requester's own valid/ready response channel.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; ready offered to the selected port only
// ISSUE | one-cycle core_start pulse; timeout counter cleared
// WAIT  | operands held on the core; waiting for core_done or timeout
// RESP  | result/err presented to the granted port until it is consumed
module tea_job_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMR_W          = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode,
  input  logic [63:0] req0_data,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_data,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode,
  input  logic [63:0] req1_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_data,
  output logic        rsp1_err,
  output logic        core_start,
  output logic        core_mode,
  output logic [31:0] core_v0,
  output logic [31:0] core_v1,
  input  logic        core_done,
  input  logic [31:0] core_v0_res,
  input  logic [31:0] core_v1_res,
  output logic        busy,
  output logic        grant_id,
  output logic [15:0] jobs_done,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_id;
  logic             r_mode;
  logic [63:0]      r_data;
  logic [63:0]      r_res;
  logic             r_err;
  logic [TMR_W-1:0] r_tmr;
  logic             r_grant_id;
  logic [15:0]      r_jobs;
  logic [7:0]       r_errs;

  logic w_idle;
  logic w_any;
  logic w_sel_id;
  logic w_accept;
  logic w_core_act;
  logic w_resp;
  logic w_rsp_ready;

  // On a tie the port that was not served last wins; otherwise the lone requester.
  assign w_idle      = (r_state == S_IDLE);
  assign w_any       = req0_valid | req1_valid;
  assign w_sel_id    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept    = w_idle & w_any;
  assign w_core_act  = (r_state == S_ISSUE) | (r_state == S_WAIT);
  assign w_resp      = (r_state == S_RESP);
  assign w_rsp_ready = r_id ? rsp1_ready : rsp0_ready;

  assign req0_ready = w_accept & ~w_sel_id;
  assign req1_ready = w_accept &  w_sel_id;

  // Operands are only driven toward the core while a job is being worked on.
  assign core_start = (r_state == S_ISSUE);
  assign core_mode  = w_core_act & r_mode;
  assign core_v0    = w_core_act ? r_data[31:0]  : 32'd0;
  assign core_v1    = w_core_act ? r_data[63:32] : 32'd0;

  assign rsp0_valid = w_resp & ~r_id;
  assign rsp1_valid = w_resp &  r_id;
  assign rsp0_data  = rsp0_valid ? r_res : 64'd0;
  assign rsp1_data  = rsp1_valid ? r_res : 64'd0;
  assign rsp0_err   = rsp0_valid & r_err;
  assign rsp1_err   = rsp1_valid & r_err;

  assign busy      = ~w_idle;
  assign grant_id  = r_grant_id;
  assign jobs_done = r_jobs;
  assign err_count = r_errs;

  // Job sequencing FSM with latched job, result capture, timeout and counters.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_mode       <= 1'b0;
      r_data       <= 64'd0;
      r_res        <= 64'd0;
      r_err        <= 1'b0;
      r_tmr        <= '0;
      r_grant_id   <= 1'b0;
      r_jobs       <= 16'd0;
      r_errs       <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id       <= w_sel_id;
            r_grant_id <= w_sel_id;
            r_mode     <= w_sel_id ? req1_mode : req0_mode;
            r_data     <= w_sel_id ? req1_data : req0_data;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmr   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A completion arriving on the last allowed cycle still counts as success.
          if (core_done) begin
            r_res   <= {core_v1_res, core_v0_res};
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_tmr == TMR_LAST) begin
            r_res   <= 64'd0;
            r_err   <= 1'b1;
            if (r_errs != 8'hFF) r_errs <= r_errs + 8'd1;
            r_state <= S_RESP;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            r_jobs       <= r_jobs + 16'd1;
            r_last_grant <= r_id;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
